// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the CPU controller and the multiply/divide unit.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, a, b, cancel,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, op, a, b, cancel,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide with HI/LO registers.
// One datapath register holds the product during MULT and {remainder, quotient} during DIV.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               dz_pend;
    logic [WIDTH-1:0]   mag;
    logic [2*WIDTH-1:0] acc;

    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        a_abs = bus.a;
        b_abs = bus.b;
        if (!bus.op[0] && bus.a[WIDTH-1]) a_abs = -bus.a;
        if (!bus.op[0] && bus.b[WIDTH-1]) b_abs = -bus.b;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag} : '0);
        rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, mag};
        prod_fix  = neg_q ? -acc : acc;
        quo_fix   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            is_div       <= 1'b0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            dz_pend      <= 1'b0;
            mag          <= '0;
            acc          <= '0;
            bus.hi       <= '0;
            bus.lo       <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.cancel) begin
                        if (!bus.op[2]) begin
                            // MULT/MULTU/DIV/DIVU: op[1] selects divide, op[0] selects unsigned
                            is_div       <= bus.op[1];
                            cnt          <= '0;
                            bus.busy     <= 1'b1;
                            bus.div_zero <= 1'b0;
                            if (bus.op[1] && bus.b == '0) begin
                                // Divide by zero: quotient all-ones, remainder is the raw dividend
                                acc     <= {bus.a, {WIDTH{1'b1}}};
                                neg_q   <= 1'b0;
                                neg_r   <= 1'b0;
                                dz_pend <= 1'b1;
                                state   <= FIX;
                            end else begin
                                mag     <= bus.op[1] ? b_abs : a_abs;
                                acc     <= {{WIDTH{1'b0}}, bus.op[1] ? a_abs : b_abs};
                                neg_q   <= !bus.op[0] && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                                neg_r   <= !bus.op[0] && bus.a[WIDTH-1];
                                dz_pend <= 1'b0;
                                state   <= CALC;
                            end
                        end else if (!bus.op[1]) begin
                            if (bus.op[0]) bus.lo <= bus.a;
                            else           bus.hi <= bus.a;
                            bus.div_zero <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    if (bus.cancel) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        if (is_div) begin
                            // Restoring step: keep the trial subtraction only if it did not borrow
                            if (rem_diff[WIDTH])
                                acc <= {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                            else
                                acc <= {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= {mul_sum, acc[WIDTH-1:1]};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) state <= FIX;
                    end
                end
                FIX: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    if (!bus.cancel) begin
                        if (is_div) begin
                            bus.lo <= quo_fix;
                            bus.hi <= rem_fix;
                        end else begin
                            {bus.hi, bus.lo} <= prod_fix;
                        end
                        bus.div_zero <= dz_pend;
                        bus.done     <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(32)) b32();
    muldiv_unit_if #(.WIDTH(8))  b8();

    muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
    muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8.slave));

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          busy;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   bc32   = 0;
    int   bc8    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    function automatic exp_t mk(input logic [31:0] hi, input logic [31:0] lo, input logic dz, input int busy);
        exp_t e;
        e.hi = hi; e.lo = lo; e.dz = dz; e.busy = busy;
        return e;
    endfunction

    // Reference: plain integer arithmetic on sign-extended 64-bit values
    function automatic exp_t model(input int w, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] m, ux, uy, p;
        longint      sx, sy, r;
        exp_t        e;
        m  = (64'd1 << w) - 64'd1;
        ux = {32'd0, x} & m;
        uy = {32'd0, y} & m;
        sx = ux[w-1] ? longint'(ux) - longint'(m) - 64'sd1 : longint'(ux);
        sy = uy[w-1] ? longint'(uy) - longint'(m) - 64'sd1 : longint'(uy);
        e.dz   = 1'b0;
        e.busy = w + 1;
        p      = '0;
        case (o)
            3'd0: begin r = sx * sy; p = r; end
            3'd1: p = ux * uy;
            default: begin
                if (uy == 0) begin
                    p = (ux << w) | m;
                    e.dz = 1'b1;
                    e.busy = 1;
                end else if (o == 3'd2) begin
                    p = (((64'(sx % sy)) & m) << w) | ((64'(sx / sy)) & m);
                end else begin
                    p = ((ux % uy) << w) | (ux / uy);
                end
            end
        endcase
        e.hi = 32'((p >> w) & m);
        e.lo = 32'(p & m);
        return e;
    endfunction

    function automatic logic [31:0] get_hi(input int w);   return (w == 32) ? b32.hi : 32'(b8.hi); endfunction
    function automatic logic [31:0] get_lo(input int w);   return (w == 32) ? b32.lo : 32'(b8.lo); endfunction
    function automatic logic        get_busy(input int w); return (w == 32) ? b32.busy : b8.busy; endfunction
    function automatic logic        get_done(input int w); return (w == 32) ? b32.done : b8.done; endfunction
    function automatic logic        get_dz(input int w);   return (w == 32) ? b32.div_zero : b8.div_zero; endfunction

    task automatic drive(input int w, input logic s, input logic c, input logic [2:0] o,
                         input logic [31:0] x, input logic [31:0] y);
        if (w == 32) begin
            b32.start = s; b32.cancel = c; b32.op = o; b32.a = x; b32.b = y;
        end else begin
            b8.start = s; b8.cancel = c; b8.op = o; b8.a = x[7:0]; b8.b = y[7:0];
        end
    endtask

    task automatic issue(input int w, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        drive(w, 1'b1, 1'b0, o, x, y);
        @(posedge clk);
        #1 drive(w, 1'b0, 1'b0, o, x, y);
    endtask

    task automatic push(input int w, input exp_t e);
        if (w == 32) q32.push_back(e);
        else         q8.push_back(e);
    endtask

    task automatic wait_done(input int w);
        int n = 0;
        while (!get_done(w) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!get_done(w)) begin
            n_chk++;
            $display("FAIL timeout%0d: no done after %0d cycles", w, n);
        end
    endtask

    task automatic mt(input int w, input logic [2:0] o, input logic [31:0] x);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        issue(w, o, x, 32'd0);
        check(o == 3'd4 ? "mthi" : "mtlo", o == 3'd4 ? get_hi(w) : get_lo(w), x & m);
        check("mt_busy", 32'(get_busy(w)), 32'd0);
    endtask

    task automatic rand_op(input int w);
        logic [2:0]  o;
        logic [31:0] x, y;
        o = 3'($urandom_range(0, 5));
        x = $urandom;
        y = $urandom;
        if ($urandom_range(0, 7) == 0) y = 32'd0;
        if ($urandom_range(0, 9) == 0) begin
            x = (w == 32) ? 32'h8000_0000 : 32'h0000_0080;
            y = 32'hFFFF_FFFF;
        end
        if (o >= 3'd4) begin
            mt(w, o, x);
        end else begin
            push(w, model(w, o, x, y));
            issue(w, o, x, y);
            wait_done(w);
        end
    endtask

    // Monitors: pop one expectation per done pulse and compare
    always @(negedge clk) begin
        exp_t e;
        if (b32.done) begin
            if (q32.size() == 0) begin
                n_chk++;
                $display("FAIL done32: unexpected done pulse, hi %h lo %h", b32.hi, b32.lo);
            end else begin
                e = q32.pop_front();
                check("hi32", b32.hi, e.hi);
                check("lo32", b32.lo, e.lo);
                check("dz32", 32'(b32.div_zero), 32'(e.dz));
                check("busy32", 32'(bc32), 32'(e.busy));
            end
            bc32 = 0;
        end else if (b32.busy) bc32++;
        else bc32 = 0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (b8.done) begin
            if (q8.size() == 0) begin
                n_chk++;
                $display("FAIL done8: unexpected done pulse, hi %h lo %h", b8.hi, b8.lo);
            end else begin
                e = q8.pop_front();
                check("hi8", 32'(b8.hi), e.hi);
                check("lo8", 32'(b8.lo), e.lo);
                check("dz8", 32'(b8.div_zero), 32'(e.dz));
                check("busy8", 32'(bc8), 32'(e.busy));
            end
            bc8 = 0;
        end else if (b8.busy) bc8++;
        else bc8 = 0;
    end

    initial begin
        drive(32, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(8, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hi", b32.hi, 32'd0);
        check("rst_lo", b32.lo, 32'd0);
        check("rst_busy", 32'(b32.busy), 32'd0);
        check("rst_done", 32'(b32.done), 32'd0);
        check("rst_dz", 32'(b32.div_zero), 32'd0);
        @(negedge clk) rst = 1'b1;

        // Asynchronous reset in the middle of a MULTU
        @(negedge clk);
        mt(32, 3'd4, 32'h55);
        mt(32, 3'd5, 32'h66);
        issue(32, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_hi", b32.hi, 32'd0);
        check("arst_lo", b32.lo, 32'd0);
        check("arst_busy", 32'(b32.busy), 32'd0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        mt(32, 3'd4, 32'h1234_5678);

        // MULTU with an ignored start ten cycles in
        @(negedge clk);
        push(32, mk(32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33));
        issue(32, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(negedge clk);
        drive(32, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        @(posedge clk);
        #1 drive(32, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        wait_done(32);

        // Signed multiply, then back-to-back issues on each done cycle
        @(negedge clk);
        push(32, mk(32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33));
        issue(32, 3'd0, 32'hFFFF_FFFD, 32'd5);
        wait_done(32);
        push(32, mk(32'd0, 32'h0000_000F, 1'b0, 33));
        issue(32, 3'd1, 32'd3, 32'd5);
        wait_done(32);
        push(32, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33));
        issue(32, 3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done(32);
        push(32, mk(32'd0, 32'h8000_0000, 1'b0, 33));
        issue(32, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(32);
        push(32, mk(32'd2, 32'h2AAA_AAAA, 1'b0, 33));
        issue(32, 3'd3, 32'h8000_0000, 32'd3);
        wait_done(32);

        // Divide by zero, then MTLO clears the sticky flag
        push(32, mk(32'd7, 32'hFFFF_FFFF, 1'b1, 1));
        issue(32, 3'd3, 32'd7, 32'd0);
        wait_done(32);
        mt(32, 3'd5, 32'h0000_CAFE);
        check("dz_clear", 32'(b32.div_zero), 32'd0);

        // Cancel mid-CALC leaves hi/lo alone and never pulses done
        @(negedge clk);
        mt(32, 3'd4, 32'hA);
        mt(32, 3'd5, 32'hB);
        issue(32, 3'd2, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        b32.cancel = 1'b1;
        @(posedge clk);
        #1 b32.cancel = 1'b0;
        check("cancel_busy", 32'(b32.busy), 32'd0);
        repeat (40) @(negedge clk);
        check("cancel_hi", b32.hi, 32'hA);
        check("cancel_lo", b32.lo, 32'hB);

        // Cancel on the FIX edge of a divide by zero
        issue(32, 3'd3, 32'd9, 32'd0);
        b32.cancel = 1'b1;
        @(posedge clk);
        #1 b32.cancel = 1'b0;
        repeat (3) @(negedge clk);
        check("cfix_busy", 32'(b32.busy), 32'd0);
        check("cfix_hi", b32.hi, 32'hA);
        check("cfix_lo", b32.lo, 32'hB);

        // start with cancel in IDLE, and reserved opcodes, do nothing
        drive(32, 1'b1, 1'b1, 3'd4, 32'hDEAD, 32'd0);
        @(posedge clk);
        #1 drive(32, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        check("sc_hi", b32.hi, 32'hA);
        check("sc_busy", 32'(b32.busy), 32'd0);
        issue(32, 3'd6, 32'h1111, 32'h2222);
        issue(32, 3'd7, 32'h3333, 32'h4444);
        check("rsv_hi", b32.hi, 32'hA);
        check("rsv_lo", b32.lo, 32'hB);
        check("rsv_busy", 32'(b32.busy), 32'd0);

        for (int i = 0; i < 60; i++) rand_op(32);

        // Narrow instance
        @(negedge clk);
        push(8, mk(32'h40, 32'h00, 1'b0, 9));
        issue(8, 3'd0, 32'h80, 32'h80);
        wait_done(8);
        push(8, mk(32'hFE, 32'h01, 1'b0, 9));
        issue(8, 3'd1, 32'hFF, 32'hFF);
        wait_done(8);
        push(8, mk(32'h00, 32'h80, 1'b0, 9));
        issue(8, 3'd2, 32'h80, 32'hFF);
        wait_done(8);
        push(8, mk(32'h07, 32'hFF, 1'b1, 1));
        issue(8, 3'd3, 32'h07, 32'h00);
        wait_done(8);
        for (int i = 0; i < 40; i++) rand_op(8);

        repeat (5) @(negedge clk);
        check("q32_drained", 32'(q32.size()), 32'd0);
        check("q8_drained", 32'(q8.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with built-in HI/LO registers for the multi-cycle CPU datapath. Replaces the separate DIV, DIVU, MULT, MULTU instances, their HI/LO write-select muxes and the HILO register with one block. The controller state machine issues one start pulse per operation and stalls on `busy`. The unit adds an abort (`cancel`) for exception entry and defines divide-by-zero behaviour.

## Interface
- `WIDTH`, default 32: operand width and width of each of HI and LO. Must be even and ≥ 4.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: operation request, sampled on the rising edge.
- `op` input 3: operation code, sampled with `start`.
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are reserved: no effect.
- `a` input WIDTH: rs operand (multiplicand / dividend / MTHI-MTLO data).
- `b` input WIDTH: rt operand (multiplier / divisor).
- `cancel` input 1: abort any in-flight operation.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.
- `busy` output 1: an operation is in flight; `start` is ignored while high.
- `done` output 1: one-cycle pulse in the cycle after a MULT/DIV result is written.
- `div_zero` output 1: sticky flag, set by DIV/DIVU with `b`==0, cleared by the next accepted `start`.

## Operation
- States: IDLE, CALC, FIX. A step counter of width clog2(WIDTH)+1 runs in CALC.
- **IDLE + start, op=MULT/MULTU/DIV/DIVU:**
  - Latch |a| and |b| (raw values for unsigned ops).
  - Latch the result signs:
    - product sign = a[W-1]^b[W-1];
    - quotient sign = a[W-1]^b[W-1];
    - remainder sign = a[W-1].
  - Clear the counter and `div_zero`; go to CALC; `busy`=1.
- **IDLE + start, op=MTHI/MTLO:** write `a` into hi (MTHI) or lo (MTLO) on that edge. Stay in IDLE, `busy` stays 0, no `done`. Clears `div_zero`.
- **CALC, multiply:** radix-2 shift-add, one multiplier bit per cycle, 2W-bit accumulator. Runs exactly WIDTH cycles, then goes to FIX.
- **CALC, divide:** restoring division, one quotient bit per cycle, W+1-bit partial remainder. Runs exactly WIDTH cycles, then goes to FIX.
- **Divide with b==0:** CALC is skipped; go directly to FIX. Result is lo = all-ones, hi = a (raw, unmodified). Set `div_zero`.
- **FIX:**
  - Apply two's-complement sign correction for signed ops only.
  - Multiply: {hi,lo} = 2W-bit product.
  - Divide: lo = quotient, hi = remainder.
  - Go to IDLE; `busy`=0; `done`=1 for the next cycle.
- **Signed overflow, DIV of MIN by -1:** lo = MIN, hi = 0. This is the natural wrap; no flag.
- **cancel:** when high on an edge in CALC or FIX, return to IDLE. hi/lo are unchanged and `done` is not pulsed. In IDLE, `cancel` suppresses a simultaneous `start`, including MTHI/MTLO.
- **start while busy:** ignored. Operands are not re-latched and `op` is not re-sampled.
- **Reset** (rst=0, asynchronous, any state): state=IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0. An in-flight result is lost.

## Timing
- Let E0 be the accepting edge. `busy` is high from after E0 until after the FIX edge.
- MULT/DIV, nonzero divisor: CALC occupies edges E1..E_WIDTH; the FIX edge is E_(WIDTH+1). hi/lo are valid and `done`=1 after E_(WIDTH+1).
- Busy time is WIDTH+1 cycles, i.e. 33 for WIDTH=32.
- Divide by zero: the FIX edge is E1; result and `done` follow after E1.
- A new `start` is accepted on the same edge on which `done` is high: back-to-back issue with zero gap cycles.
- MTHI/MTLO: hi/lo are updated at E0; zero latency, no busy cycle.
- hi and lo are registered outputs. `a` and `b` need to be stable only at E0.

## Test plan
- **Reset:** assert rst=0 mid-CALC of a MULTU → hi=lo=0, busy=0 immediately (asynchronous). Release reset, then issue MTHI 0x12345678 → hi=0x12345678 after one edge, busy never high.
- **Unsigned multiply:** MULTU 0xFFFFFFFF×0xFFFFFFFF → busy high exactly 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done one cycle. A second `start` 10 cycles in is ignored (operands changed to 0, result unchanged).
- **Signed multiply:** MULT -3×5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then, back-to-back on the `done` cycle, MULTU 3×5 → hi=0, lo=0x0000000F.
- **Signed divide:**
  - DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
  - DIVU 0x80000000/3 → lo=0x2AAAAAAA, hi=2.
- **Divide by zero:** DIVU 7/0 → after 2 edges lo=0xFFFFFFFF, hi=7, div_zero=1, done pulses. The next MTLO clears div_zero.
- **Cancel:**
  - Preload hi=0xA, lo=0xB, start DIV 100/7, assert cancel on cycle 5 → IDLE, hi=0xA, lo=0xB, no done.
  - start+cancel together in IDLE → nothing happens.
- **Parametric:** repeat the MULTU/DIV checks at WIDTH=8, e.g. MULT 0x80×0x80 → hi=0x40, lo=0x00; busy 9 cycles.
